lcd_fill: RTL

LCD_FILL -- requirements
Module: lcd_fill

---
 rtl/lcd_fill.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_fill.sv
// LCD rectangle filler: boots the panel (SLPOUT, COLMOD=565, DISPON), then turns each
// accepted fill request into a CASET/RASET/RAMWR command stream plus RGB565 pixel bytes.
//
// state | meaning
// BOOT  | power-up wait, BOOT_DELAY cycles, no bytes
// INIT  | presenting SLPOUT (0x11) until it transfers
// SLEEP | post-SLPOUT wait, SLEEP_DELAY cycles
// INIT2 | presenting 0x3A, 0x55, 0x29
// IDLE  | ready, start accepted here only
// ADDR  | presenting the 11 window/RAMWR bytes
// PIX   | presenting pixel bytes, high then low

module lcd_fill #(
    parameter int BOOT_DELAY  = 12000,
    parameter int SLEEP_DELAY = 1200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    input  logic [15:0] color,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        dc,
    output logic [7:0]  out,
    output logic        put,
    input  logic        full
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        INIT  = 3'd1,
        SLEEP = 3'd2,
        INIT2 = 3'd3,
        IDLE  = 3'd4,
        ADDR  = 3'd5,
        PIX   = 3'd6
    } state_t;

    state_t       state_q, state_d;
    logic         pending_q, pending_d;
    logic         dc_q, dc_d;
    logic [7:0]   out_q, out_d;
    logic [31:0]  timer_q, timer_d;
    logic [3:0]   step_q, step_d;
    logic [16:0]  pix_q, pix_d;
    logic         phase_q, phase_d;
    logic         done_q, done_d;
    logic [7:0]   x0_q, x1_q, y0_q, y1_q;
    logic [7:0]   x0_d, x1_d, y0_d, y1_d;
    logic [15:0]  color_q, color_d;

    logic         xfer;
    logic         win_empty;
    logic [16:0]  win_w, win_h, win_pix;

    assign xfer      = pending_q & ~full;
    assign win_empty = (x1 < x0) || (y1 < y0);
    assign win_w     = {9'd0, x1} - {9'd0, x0} + 17'd1;
    assign win_h     = {9'd0, y1} - {9'd0, y0} + 17'd1;
    // 256*256 = 65536 still fits in 17 bits; garbage for empty windows is never used
    assign win_pix   = win_w * win_h;

    function automatic logic [8:0] addr_byte(
        input logic [3:0] idx,
        input logic [7:0] ax0,
        input logic [7:0] ax1,
        input logic [7:0] ay0,
        input logic [7:0] ay1
    );
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, 8'h2A};
            4'd1:    b = {1'b1, 8'h00};
            4'd2:    b = {1'b1, ax0};
            4'd3:    b = {1'b1, 8'h00};
            4'd4:    b = {1'b1, ax1};
            4'd5:    b = {1'b0, 8'h2B};
            4'd6:    b = {1'b1, 8'h00};
            4'd7:    b = {1'b1, ay0};
            4'd8:    b = {1'b1, 8'h00};
            4'd9:    b = {1'b1, ay1};
            default: b = {1'b0, 8'h2C};
        endcase
        return b;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            pending_q <= 1'b0;
            dc_q      <= 1'b0;
            out_q     <= 8'h00;
            timer_q   <= '0;
            step_q    <= '0;
            pix_q     <= '0;
            phase_q   <= 1'b0;
            done_q    <= 1'b0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dc_q      <= dc_d;
            out_q     <= out_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            pix_q     <= pix_d;
            phase_q   <= phase_d;
            done_q    <= done_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            color_q   <= color_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dc_d      = dc_q;
        out_d     = out_q;
        timer_d   = timer_q;
        step_d    = step_q;
        pix_d     = pix_q;
        phase_d   = phase_q;
        done_d    = 1'b0;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        color_d   = color_q;

        case (state_q)
            BOOT: begin
                if (timer_q == 32'(BOOT_DELAY - 1)) begin
                    state_d   = INIT;
                    timer_d   = '0;
                    pending_d = 1'b1;
                    dc_d      = 1'b0;
                    out_d     = 8'h11;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            INIT: begin
                if (xfer) begin
                    state_d   = SLEEP;
                    pending_d = 1'b0;
                    timer_d   = '0;
                end
            end
            SLEEP: begin
                if (timer_q == 32'(SLEEP_DELAY - 1)) begin
                    state_d   = INIT2;
                    timer_d   = '0;
                    step_d    = '0;
                    pending_d = 1'b1;
                    dc_d      = 1'b0;
                    out_d     = 8'h3A;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            INIT2: begin
                if (xfer) begin
                    case (step_q)
                        4'd0: begin
                            step_d = 4'd1;
                            dc_d   = 1'b1;
                            out_d  = 8'h55;
                        end
                        4'd1: begin
                            step_d = 4'd2;
                            dc_d   = 1'b0;
                            out_d  = 8'h29;
                        end
                        default: begin
                            state_d   = IDLE;
                            step_d    = '0;
                            pending_d = 1'b0;
                        end
                    endcase
                end
            end
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    x1_d    = x1;
                    y0_d    = y0;
                    y1_d    = y1;
                    color_d = color;
                    if (win_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = ADDR;
                        step_d    = '0;
                        pix_d     = win_pix;
                        pending_d = 1'b1;
                        dc_d      = 1'b0;
                        out_d     = 8'h2A;
                    end
                end
            end
            ADDR: begin
                if (xfer) begin
                    if (step_q == 4'd10) begin
                        state_d = PIX;
                        step_d  = '0;
                        phase_d = 1'b0;
                        dc_d    = 1'b1;
                        out_d   = color_q[15:8];
                    end else begin
                        step_d        = step_q + 4'd1;
                        {dc_d, out_d} = addr_byte(step_q + 4'd1, x0_q, x1_q, y0_q, y1_q);
                    end
                end
            end
            PIX: begin
                if (xfer) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        out_d   = color_q[7:0];
                    end else if (pix_q == 17'd1) begin
                        state_d   = IDLE;
                        pending_d = 1'b0;
                        pix_d     = '0;
                        phase_d   = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        pix_d   = pix_q - 17'd1;
                        phase_d = 1'b0;
                        out_d   = color_q[15:8];
                    end
                end
            end
            default: begin
                state_d   = BOOT;
                pending_d = 1'b0;
                timer_d   = '0;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign dc   = dc_q;
    assign out  = out_q;
    assign put  = pending_q & ~full;

endmodule
